// File: rtl/stepper_motor.sv
// Two-phase stepper sequencer: divides clk_in down to a step rate and walks a
// Gray-coded coil pattern forward or backward depending on a synchronized direction switch.
module stepper_motor #(
  parameter int STEP_DIV = 1,
  parameter int CNT_W    = 24
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       Direction,
  output logic [1:0] LED
);

  localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             dir_s1;
  logic             dir_s;
  logic [1:0]       phase;
  logic [1:0]       phase_nxt;
  logic             step_tick;

  assign step_tick = (div_cnt == TICK_AT);
  assign phase_nxt = dir_s ? (phase + 2'd1) : (phase - 2'd1);

  // LED is loaded with the Gray code of the phase being entered, so it moves on the tick edge itself.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_cnt <= '0;
      dir_s1  <= 1'b0;
      dir_s   <= 1'b0;
      phase   <= 2'd0;
      LED     <= 2'b00;
    end else begin
      dir_s1 <= Direction;
      dir_s  <= dir_s1;
      if (step_tick) begin
        div_cnt <= '0;
        phase   <= phase_nxt;
        LED     <= phase_nxt ^ {1'b0, phase_nxt[1]};
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stepper_motor.sv
// Bench for stepper_motor: directed vector table on two divider settings, then
// randomized direction/reset traffic checked against a step-rule reference model.
module tb_stepper_motor;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       direction;
  logic [1:0] led_a;
  logic [1:0] led_b;

  always #5 clk_in = ~clk_in;

  stepper_motor #(.STEP_DIV(1), .CNT_W(24)) dut_a (
    .clk_in(clk_in), .reset(reset), .Direction(direction), .LED(led_a)
  );

  stepper_motor #(.STEP_DIV(4), .CNT_W(2)) dut_b (
    .clk_in(clk_in), .reset(reset), .Direction(direction), .LED(led_b)
  );

  typedef struct {
    bit         rst;
    bit         dir;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase is an integer mod 4, a step happens on every D-th
  // edge since release, and it uses the Direction value sampled two edges earlier.
  int         div_of  [2] = '{1, 4};
  int         m_phase [2];
  int         m_edges [2];
  logic [1:0] m_led   [2];
  logic [1:0] gray_tab[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  bit         dir_hist[$];

  task automatic model_edge(input bit r, input bit d);
    bit use_dir;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = 0;
        m_edges[i] = 0;
        m_led[i]   = 2'b00;
      end
      dir_hist = '{1'b0, 1'b0};
    end else begin
      use_dir = dir_hist[1];
      for (int i = 0; i < 2; i++) begin
        m_edges[i]++;
        if (m_edges[i] % div_of[i] == 0) begin
          m_phase[i] = (m_phase[i] + (use_dir ? 1 : 3)) % 4;
          m_led[i]   = gray_tab[m_phase[i]];
        end
      end
      dir_hist.push_front(d);
      void'(dir_hist.pop_back());
    end
  endtask

  task automatic cycle(input bit r, input bit d);
    reset     = r;
    direction = d;
    @(posedge clk_in);
    model_edge(r, d);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [1:0] got, input logic [1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d] got=%b expected=%b", name, idx, got, exp);
  endtask

  vec_t vecs[$];

  initial begin
    logic [1:0] prev_a;
    logic [1:0] prev_b;
    bit         r;
    bit         d;

    dir_hist  = '{1'b0, 1'b0};
    reset     = 1'b1;
    direction = 1'b1;

    // Direction held high through reset, release, divider and reset-mid-run,
    // then reverse stepping, then a 0->1 flip.
    vecs = '{
      '{1'b1, 1'b1, 2'b00, 2'b00},
      '{1'b1, 1'b1, 2'b00, 2'b00},
      '{1'b1, 1'b1, 2'b00, 2'b00},
      '{1'b0, 1'b1, 2'b10, 2'b00},
      '{1'b0, 1'b1, 2'b11, 2'b00},
      '{1'b0, 1'b1, 2'b10, 2'b00},
      '{1'b0, 1'b1, 2'b00, 2'b01},
      '{1'b0, 1'b1, 2'b01, 2'b01},
      '{1'b0, 1'b1, 2'b11, 2'b01},
      '{1'b0, 1'b1, 2'b10, 2'b01},
      '{1'b0, 1'b1, 2'b00, 2'b11},
      '{1'b0, 1'b1, 2'b01, 2'b11},
      '{1'b0, 1'b1, 2'b11, 2'b11},
      '{1'b1, 1'b0, 2'b00, 2'b00},
      '{1'b0, 1'b0, 2'b10, 2'b00},
      '{1'b0, 1'b0, 2'b11, 2'b00},
      '{1'b0, 1'b0, 2'b01, 2'b00},
      '{1'b0, 1'b0, 2'b00, 2'b10},
      '{1'b0, 1'b0, 2'b10, 2'b10},
      '{1'b0, 1'b1, 2'b11, 2'b10},
      '{1'b0, 1'b1, 2'b01, 2'b10},
      '{1'b0, 1'b1, 2'b11, 2'b00},
      '{1'b0, 1'b1, 2'b10, 2'b00}
    };

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].dir);
      check("vec_div1", i, led_a, vecs[i].exp_a);
      check("vec_div4", i, led_b, vecs[i].exp_b);
    end

    // Reset held while Direction toggles: output must stay 00.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, i[0]);
      check("rst_hold_div1", i, led_a, 2'b00);
      check("rst_hold_div4", i, led_b, 2'b00);
    end

    prev_a = led_a;
    prev_b = led_b;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      d = (i % 16 < 8) ? $urandom_range(0, 1) : d;
      cycle(r, d);
      check("rand_div1", i, led_a, m_led[0]);
      check("rand_div4", i, led_b, m_led[1]);
      if (!r) begin
        check("onebit_div1", i, {1'b0, $countones(led_a ^ prev_a) <= 1}, 2'b01);
        check("onebit_div4", i, {1'b0, $countones(led_b ^ prev_b) <= 1}, 2'b01);
      end
      prev_a = led_a;
      prev_b = led_b;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
